// File: rtl/fft16_ctrl.sv
// fft16_ctrl: sequencer for a 16-point radix-2 in-place DIT FFT.
// Issues one butterfly per cycle (4 stages x 8), drains the butterfly
// pipeline between stages and replays read addresses as write-back.
// Optional sample-load phase: define FFT16_CTRL_LOAD_EN.
module fft16_ctrl #(
  parameter int BF_LAT = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
`ifdef FFT16_CTRL_LOAD_EN
  input  logic       i_ld_valid,
  output logic       o_ld_we,
  output logic [3:0] o_ld_addr,
`endif
  output logic       o_busy,
  output logic       o_done,
  output logic       o_rd_en,
  output logic [3:0] o_rd_addr0,
  output logic [3:0] o_rd_addr1,
  output logic [2:0] o_tw_idx,
  output logic [1:0] o_stage,
  output logic       o_wr_en,
  output logic [3:0] o_wr_addr0,
  output logic [3:0] o_wr_addr1
);

`ifdef FFT16_CTRL_LOAD_EN
  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, DRAIN, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
`endif

  // Drain lasts 1 (memory read) + BF_LAT (butterfly) cycles.
  localparam logic [2:0] DRAIN_LAST = 3'(BF_LAT);

  state_t     state, state_nxt;
  logic [1:0] stg, stg_nxt;
  logic [2:0] bfy, bfy_nxt;
  logic [2:0] cnt, cnt_nxt;
`ifdef FFT16_CTRL_LOAD_EN
  logic [3:0] ld_cnt, ld_cnt_nxt;
`endif

  logic       issue_nxt;
  logic [3:0] span, pos, addr0, addr1;
  logic [2:0] tw;

  logic [BF_LAT:0]       vld_pipe;
  logic [BF_LAT:0][3:0]  a0_pipe;
  logic [BF_LAT:0][3:0]  a1_pipe;

  // State, stage, butterfly and drain counters.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= IDLE;
      stg    <= '0;
      bfy    <= '0;
      cnt    <= '0;
`ifdef FFT16_CTRL_LOAD_EN
      ld_cnt <= '0;
`endif
    end else begin
      state  <= state_nxt;
      stg    <= stg_nxt;
      bfy    <= bfy_nxt;
      cnt    <= cnt_nxt;
`ifdef FFT16_CTRL_LOAD_EN
      ld_cnt <= ld_cnt_nxt;
`endif
    end
  end

  // Next-state logic; i_start is only looked at in IDLE.
  always_comb begin
    state_nxt = state;
    stg_nxt   = stg;
    bfy_nxt   = bfy;
    cnt_nxt   = cnt;
`ifdef FFT16_CTRL_LOAD_EN
    ld_cnt_nxt = ld_cnt;
`endif
    case (state)
      IDLE: if (i_start) begin
        stg_nxt = '0;
        bfy_nxt = '0;
        cnt_nxt = '0;
`ifdef FFT16_CTRL_LOAD_EN
        ld_cnt_nxt = '0;
        state_nxt  = LOAD;
`else
        state_nxt  = ISSUE;
`endif
      end
`ifdef FFT16_CTRL_LOAD_EN
      LOAD: if (i_ld_valid) begin
        ld_cnt_nxt = ld_cnt + 4'd1;
        if (ld_cnt == 4'd15) state_nxt = ISSUE;
      end
`endif
      ISSUE: begin
        if (bfy == 3'd7) begin
          state_nxt = DRAIN;
          bfy_nxt   = '0;
          cnt_nxt   = '0;
        end else begin
          bfy_nxt = bfy + 3'd1;
        end
      end
      DRAIN: begin
        if (cnt == DRAIN_LAST) begin
          if (stg == 2'd3) begin
            state_nxt = DONE;
          end else begin
            state_nxt = ISSUE;
            stg_nxt   = stg + 2'd1;
          end
        end else begin
          cnt_nxt = cnt + 3'd1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        stg_nxt   = '0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Butterfly addressing for the (stage, butterfly) issued next cycle.
  always_comb begin
    issue_nxt = (state_nxt == ISSUE);
    span  = 4'd1 << stg_nxt;
    pos   = {1'b0, bfy_nxt} & (span - 4'd1);
    addr0 = (({1'b0, bfy_nxt} - pos) << 1) + pos;
    addr1 = addr0 + span;
    tw    = 3'(pos << (2'd3 - stg_nxt));
  end

  // Registered read request; fields are zero when nothing is issued.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rd_en    <= 1'b0;
      o_rd_addr0 <= '0;
      o_rd_addr1 <= '0;
      o_tw_idx   <= '0;
      o_stage    <= '0;
    end else begin
      o_rd_en    <= issue_nxt;
      o_rd_addr0 <= issue_nxt ? addr0   : 4'd0;
      o_rd_addr1 <= issue_nxt ? addr1   : 4'd0;
      o_tw_idx   <= issue_nxt ? tw      : 3'd0;
      o_stage    <= issue_nxt ? stg_nxt : 2'd0;
    end
  end

  // Write-back pipeline: read request delayed by 1 + BF_LAT cycles.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_pipe <= '0;
      a0_pipe  <= '0;
      a1_pipe  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[BF_LAT-1:0], o_rd_en};
      a0_pipe  <= {a0_pipe[BF_LAT-1:0], o_rd_addr0};
      a1_pipe  <= {a1_pipe[BF_LAT-1:0], o_rd_addr1};
    end
  end

  assign o_wr_en    = vld_pipe[BF_LAT];
  assign o_wr_addr0 = a0_pipe[BF_LAT];
  assign o_wr_addr1 = a1_pipe[BF_LAT];
  assign o_done     = (state == DONE);

`ifdef FFT16_CTRL_LOAD_EN
  assign o_busy    = (state == LOAD) || (state == ISSUE) || (state == DRAIN);
  assign o_ld_we   = (state == LOAD) && i_ld_valid;
  assign o_ld_addr = {ld_cnt[0], ld_cnt[1], ld_cnt[2], ld_cnt[3]};
`else
  assign o_busy    = (state == ISSUE) || (state == DRAIN);
`endif

endmodule

// File: tb/tb_fft16_ctrl.sv
// tb_fft16_ctrl: two controllers (BF_LAT=2 and BF_LAT=5) driven by a
// directed schedule and checked every cycle against a cycle-indexed
// expectation table built from the transform's timing rules.
// Honors FFT16_CTRL_LOAD_EN for the load-phase variant.
module tb_fft16_ctrl;
  localparam int N = 700;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_i   [2];
  logic       start_i [2];
  logic       ld_valid;
  logic       busy    [2];
  logic       done    [2];
  logic       rd_en   [2];
  logic [3:0] rd_a0   [2];
  logic [3:0] rd_a1   [2];
  logic [2:0] tw_idx  [2];
  logic [1:0] stage   [2];
  logic       wr_en   [2];
  logic [3:0] wr_a0   [2];
  logic [3:0] wr_a1   [2];
  logic       ld_we   [2];
  logic [3:0] ld_addr [2];

  fft16_ctrl #(.BF_LAT(2)) dut_a (
    .i_clk(clk), .i_rst(rst_i[0]), .i_start(start_i[0]),
`ifdef FFT16_CTRL_LOAD_EN
    .i_ld_valid(ld_valid), .o_ld_we(ld_we[0]), .o_ld_addr(ld_addr[0]),
`endif
    .o_busy(busy[0]), .o_done(done[0]), .o_rd_en(rd_en[0]),
    .o_rd_addr0(rd_a0[0]), .o_rd_addr1(rd_a1[0]), .o_tw_idx(tw_idx[0]),
    .o_stage(stage[0]), .o_wr_en(wr_en[0]), .o_wr_addr0(wr_a0[0]),
    .o_wr_addr1(wr_a1[0])
  );

  fft16_ctrl #(.BF_LAT(5)) dut_b (
    .i_clk(clk), .i_rst(rst_i[1]), .i_start(start_i[1]),
`ifdef FFT16_CTRL_LOAD_EN
    .i_ld_valid(ld_valid), .o_ld_we(ld_we[1]), .o_ld_addr(ld_addr[1]),
`endif
    .o_busy(busy[1]), .o_done(done[1]), .o_rd_en(rd_en[1]),
    .o_rd_addr0(rd_a0[1]), .o_rd_addr1(rd_a1[1]), .o_tw_idx(tw_idx[1]),
    .o_stage(stage[1]), .o_wr_en(wr_en[1]), .o_wr_addr0(wr_a0[1]),
    .o_wr_addr1(wr_a1[1])
  );

`ifndef FFT16_CTRL_LOAD_EN
  initial begin
    ld_valid = 1'b0;
    ld_we[0] = 1'b0; ld_we[1] = 1'b0;
    ld_addr[0] = 4'd0; ld_addr[1] = 4'd0;
  end
`endif

  // Stimulus and expectation tables, indexed [instance][cycle].
  bit       s_rst   [2][N];
  bit       s_start [2][N];
  bit       e_rd    [2][N];
  bit       e_wr    [2][N];
  bit       e_busy  [2][N];
  bit       e_done  [2][N];
  bit       e_ldwe  [2][N];
  bit       e_zero  [2][N];
  bit [3:0] e_ra0   [2][N];
  bit [3:0] e_ra1   [2][N];
  bit [2:0] e_tw    [2][N];
  bit [1:0] e_stg   [2][N];
  bit [3:0] e_wa0   [2][N];
  bit [3:0] e_wa1   [2][N];
  bit [3:0] e_lda   [2][N];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Butterfly b of stage s: groups of 2*span points, b%span inside a group.
  function automatic int m_addr0(input int s, input int b);
    int span = 1 << s;
    return (b / span) * 2 * span + (b % span);
  endfunction

  function automatic int m_tw(input int s, input int b);
    int span = 1 << s;
    return (b % span) * (8 / span);
  endfunction

  function automatic int m_rev(input int n);
    int r = 0;
    for (int i = 0; i < 4; i++) r = r * 2 + ((n >> i) & 1);
    return r;
  endfunction

  // Fill the expected timeline of one transform accepted in cycle t0.
  task automatic plan(input int k, input int t0, input int lat, output int dc);
    int t, c, w, a0, n;
    t = t0 + 1;
`ifdef FFT16_CTRL_LOAD_EN
    n = 0;
    while (n < 16) begin
      e_busy[k][t] = 1'b1;
      if (t % 2 == 1) begin
        e_ldwe[k][t] = 1'b1;
        e_lda[k][t]  = 4'(m_rev(n));
        n++;
      end
      t++;
    end
`else
    n = 0;
`endif
    for (int s = 0; s < 4; s++)
      for (int b = 0; b < 8; b++) begin
        c  = t + s * (9 + lat) + b;
        w  = c + 1 + lat;
        a0 = m_addr0(s, b);
        e_rd[k][c]  = 1'b1;
        e_ra0[k][c] = 4'(a0);
        e_ra1[k][c] = 4'(a0 + (1 << s));
        e_tw[k][c]  = 3'(m_tw(s, b));
        e_stg[k][c] = 2'(s);
        e_wr[k][w]  = 1'b1;
        e_wa0[k][w] = 4'(a0);
        e_wa1[k][w] = 4'(a0 + (1 << s));
      end
    dc = t + 4 * (9 + lat);
    for (int i = t; i < dc; i++) e_busy[k][i] = 1'b1;
    e_done[k][dc] = 1'b1;
  endtask

  // A reset taking effect in cycle tc wipes everything from there on.
  task automatic abort(input int k, input int tc);
    for (int i = tc; i < N; i++) begin
      e_rd[k][i] = 0; e_wr[k][i] = 0; e_busy[k][i] = 0; e_done[k][i] = 0;
      e_ldwe[k][i] = 0;
    end
    e_zero[k][tc] = 1'b1;
  endtask

  task automatic chk(input string nm, input int c, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle %0d: got %0h want %0h", nm, c, act, exp);
    end
  endtask

  task automatic drive(input int c);
    for (int k = 0; k < 2; k++) begin
      rst_i[k]   = s_rst[k][c];
      start_i[k] = s_start[k][c];
    end
`ifdef FFT16_CTRL_LOAD_EN
    ld_valid = (c % 2 == 1);
`endif
  endtask

  task automatic compare(input int c);
    for (int k = 0; k < 2; k++) begin
      chk(k ? "b.rd_en" : "a.rd_en", c, 8'(rd_en[k]), 8'(e_rd[k][c]));
      chk(k ? "b.wr_en" : "a.wr_en", c, 8'(wr_en[k]), 8'(e_wr[k][c]));
      chk(k ? "b.busy"  : "a.busy",  c, 8'(busy[k]),  8'(e_busy[k][c]));
      chk(k ? "b.done"  : "a.done",  c, 8'(done[k]),  8'(e_done[k][c]));
`ifdef FFT16_CTRL_LOAD_EN
      chk(k ? "b.ld_we" : "a.ld_we", c, 8'(ld_we[k]), 8'(e_ldwe[k][c]));
      if (e_ldwe[k][c]) chk("ld_addr", c, 8'(ld_addr[k]), 8'(e_lda[k][c]));
`endif
      if (e_rd[k][c]) begin
        chk("rd_addr0", c, 8'(rd_a0[k]),  8'(e_ra0[k][c]));
        chk("rd_addr1", c, 8'(rd_a1[k]),  8'(e_ra1[k][c]));
        chk("tw_idx",   c, 8'(tw_idx[k]), 8'(e_tw[k][c]));
        chk("stage",    c, 8'(stage[k]),  8'(e_stg[k][c]));
      end
      if (e_wr[k][c]) begin
        chk("wr_addr0", c, 8'(wr_a0[k]), 8'(e_wa0[k][c]));
        chk("wr_addr1", c, 8'(wr_a1[k]), 8'(e_wa1[k][c]));
      end
      if (e_zero[k][c])
        chk("post_rst_fields", c,
            8'({rd_a0[k], rd_a1[k]} | {wr_a0[k], wr_a1[k]} |
               {1'b0, tw_idx[k], 2'b0, stage[k]}), 8'd0);
    end
    // Hand-computed anchors.
`ifndef FFT16_CTRL_LOAD_EN
    if (c == 33) begin
      chk("s2b5.addr0", c, 8'(rd_a0[0]), 8'd9);
      chk("s2b5.addr1", c, 8'(rd_a1[0]), 8'd13);
      chk("s2b5.tw",    c, 8'(tw_idx[0]), 8'd2);
    end
    if (c == 45) begin
      chk("s3b6.addr0", c, 8'(rd_a0[0]), 8'd6);
      chk("s3b6.addr1", c, 8'(rd_a1[0]), 8'd14);
      chk("s3b6.tw",    c, 8'(tw_idx[0]), 8'd6);
    end
    if (c == 50) chk("lat2.done", c, 8'(done[0]), 8'd1);
    if (c == 62) chk("lat5.done", c, 8'(done[1]), 8'd1);
`else
    if (c == 9) begin
      chk("ld2.we",   c, 8'(ld_we[0]), 8'd1);
      chk("ld2.addr", c, 8'(ld_addr[0]), 8'd8);
    end
    if (c == 37) chk("last_ld.rd_en",  c, 8'(rd_en[0]), 8'd0);
    if (c == 38) chk("first_rd.rd_en", c, 8'(rd_en[0]), 8'd1);
`endif
  endtask

  initial begin
    int d1, dx, d2, d3a, d3b, db, t2, t3, last;
    // Model pins.
    chk("model.addr0(2,5)", 0, 8'(m_addr0(2, 5)), 8'd9);
    chk("model.tw(2,5)",    0, 8'(m_tw(2, 5)),    8'd2);
    chk("model.addr0(3,6)", 0, 8'(m_addr0(3, 6)), 8'd6);
    chk("model.tw(3,6)",    0, 8'(m_tw(3, 6)),    8'd6);
    chk("model.rev(1)",     0, 8'(m_rev(1)),      8'd8);
    chk("model.rev(3)",     0, 8'(m_rev(3)),      8'd12);

    // Instance A: single pulse, reset abort + restart, held start.
    plan(0, 5, 2, d1);
    t2 = d1 + 10;
    plan(0, t2, 2, dx);
    abort(0, t2 + 21);
    plan(0, t2 + 25, 2, d2);
    t3 = d2 + 10;
    plan(0, t3, 2, d3a);
    plan(0, d3a + 1, 2, d3b);
    // Instance B: single pulse with the deeper butterfly.
    plan(1, 5, 5, db);
`ifndef FFT16_CTRL_LOAD_EN
    chk("model.lat2_done", 0, 8'(d1), 8'd50);
    chk("model.lat5_done", 0, 8'(db), 8'd62);
`endif

    for (int i = 0; i < 3; i++) begin
      s_rst[0][i] = 1'b1;
      s_rst[1][i] = 1'b1;
    end
    e_zero[0][1] = 1'b1;
    e_zero[1][1] = 1'b1;
    s_start[0][5]       = 1'b1;
    s_start[0][t2]      = 1'b1;
    s_rst[0][t2 + 20]   = 1'b1;
    s_start[0][t2 + 25] = 1'b1;
    s_start[0][t2 + 40] = 1'b1;   // lands mid-transform, must be ignored
    for (int i = t3; i <= d3b; i++) s_start[0][i] = 1'b1;
    s_start[1][5] = 1'b1;
    last = d3b + 10;

    cyc = 0;
    drive(0);
    while (cyc < last) begin
      @(posedge clk);
      #1;
      cyc++;
      drive(cyc);
      @(negedge clk);
      compare(cyc);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
